// File: rtl/tts_host_msg_dispatch_if.sv
// Host-message dispatcher bus: input beat stream, RAM control block request
// and read-return channels, read-response stream and the drop counter.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// on a rising clock edge where valid and ready are both 1. Once valid is raised
// the sender holds valid and its payload unchanged until that edge. ready may
// change freely. ram_rd_valid is a one-cycle strobe with no back-pressure.
interface tts_host_msg_dispatch_if #(
    parameter int DATA_BYTES = 24,
    parameter int BEAT_BYTES = 8,
    parameter int NUM_RAMS   = 4
);
    logic                             in_valid;
    logic                             in_ready;
    logic [BEAT_BYTES*8-1:0]          in_data;
    logic                             in_last;
    logic [NUM_RAMS-1:0]              ram_req_valid;
    logic [NUM_RAMS-1:0]              ram_req_ready;
    logic                             ram_we;
    logic [15:0]                      ram_addr;
    logic [DATA_BYTES-1:0]            ram_be;
    logic [DATA_BYTES*8-1:0]          ram_wdata;
    logic [NUM_RAMS-1:0]              ram_rd_valid;
    logic [NUM_RAMS*DATA_BYTES*8-1:0] ram_rd_data;
    logic                             resp_valid;
    logic                             resp_ready;
    logic [DATA_BYTES*8-1:0]          resp_data;
    logic [15:0]                      err_cnt;

    // Host / RAM-side environment.
    modport master (
        output in_valid, in_data, in_last, ram_req_ready, ram_rd_valid,
               ram_rd_data, resp_ready,
        input  in_ready, ram_req_valid, ram_we, ram_addr, ram_be, ram_wdata,
               resp_valid, resp_data, err_cnt
    );

    // Dispatcher.
    modport slave (
        input  in_valid, in_data, in_last, ram_req_ready, ram_rd_valid,
               ram_rd_data, resp_ready,
        output in_ready, ram_req_valid, ram_we, ram_addr, ram_be, ram_wdata,
               resp_valid, resp_data, err_cnt
    );
endinterface

// File: rtl/tts_host_msg_dispatch.sv
// Host-message dispatcher: collects a message (cmd, ram, addr, res, byte
// enables, data) from a beat stream, validates it and issues one write or read
// to the one-hot selected RAM control block; read data returns on the response
// stream. Dropped messages bump a saturating error counter.
// Optional build macro TTS_HOST_TMO_EN: adds a TMO_CYC-cycle timeout on the
// request and read-return waits.
module tts_host_msg_dispatch #(
    parameter int DATA_BYTES = 24,
    parameter int BEAT_BYTES = 8,
    parameter int NUM_RAMS   = 4,
    parameter int TMO_CYC    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tts_host_msg_dispatch_if.slave        bus,
    output logic [2:0]                    fsm_state
);
    localparam int BE_BYTES  = DATA_BYTES / 8;
    localparam int MSG_BYTES = 5 + BE_BYTES + DATA_BYTES;
    localparam int NB        = MSG_BYTES / BEAT_BYTES;
    localparam int DATA_W    = DATA_BYTES * 8;
    localparam int MSG_W     = MSG_BYTES * 8;
    localparam int CNT_W     = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    if ((DATA_BYTES % 8) != 0 || DATA_BYTES < 8) begin : g_bad_data
        $error("DATA_BYTES must be a positive multiple of 8");
    end
    if ((MSG_BYTES % BEAT_BYTES) != 0) begin : g_bad_beat
        $error("message size must be a multiple of BEAT_BYTES");
    end
    if (NUM_RAMS < 1 || NUM_RAMS > 8) begin : g_bad_rams
        $error("NUM_RAMS must be 1..8");
    end
    if (TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_tmo
        $error("TMO_CYC must be 1..65535");
    end

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        DRAIN   = 3'd1,
        DECODE  = 3'd2,
        ISSUE   = 3'd3,
        WAIT_RD = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    beat_cnt;
    logic [MSG_W-1:0]    msg;
    logic [NUM_RAMS-1:0] sel;
    logic                is_write;
`ifdef TTS_HOST_TMO_EN
    logic [15:0]         tmo_cnt;
`endif

    // Message fields; byte 0 (cmd) sits in the MSBs once all beats are in.
    logic [7:0]            cmd_f;
    logic [7:0]            ram_f;
    logic [15:0]           addr_f;
    logic [7:0]            res_f;
    logic [DATA_BYTES-1:0] be_f;
    logic [DATA_W-1:0]     data_f;

    assign cmd_f  = msg[MSG_W-1  -: 8];
    assign ram_f  = msg[MSG_W-9  -: 8];
    assign addr_f = msg[MSG_W-17 -: 16];
    assign res_f  = msg[MSG_W-33 -: 8];
    assign be_f   = msg[MSG_W-41 -: DATA_BYTES];
    assign data_f = msg[DATA_W-1:0];

    // The reserved byte carries no meaning for the dispatcher.
    logic unused_res;
    assign unused_res = &{1'b0, res_f};

    assign fsm_state = state;

    // A select is usable only when exactly one bit is set and it names an
    // existing RCB channel.
    function automatic logic ram_sel_ok(input logic [7:0] r);
        int   ones;
        logic high;
        ones = 0;
        high = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                ones++;
                if (i >= NUM_RAMS) high = 1'b1;
            end
        end
        return (ones == 1) && !high;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                decode_ok;
    logic                req_hit;
    logic                rd_hit;
    logic [DATA_W-1:0]   rd_slice;

    // Decode verdict, request handshake and read-return slice for the
    // selected channel; strobes on other channels are ignored.
    always_comb begin
        decode_ok = ram_sel_ok(ram_f) && (cmd_f == CMD_WR || cmd_f == CMD_RD);
        req_hit   = |(sel & bus.ram_req_ready);
        rd_hit    = 1'b0;
        rd_slice  = '0;
        for (int i = 0; i < NUM_RAMS; i++) begin
            if (sel[i] && bus.ram_rd_valid[i]) begin
                rd_hit   = 1'b1;
                rd_slice = bus.ram_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Message FSM with registered outputs; in_ready is 1 only in COLLECT/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= COLLECT;
            beat_cnt          <= '0;
            msg               <= '0;
            sel               <= '0;
            is_write          <= 1'b0;
            bus.in_ready      <= 1'b0;
            bus.ram_req_valid <= '0;
            bus.ram_we        <= 1'b0;
            bus.ram_addr      <= '0;
            bus.ram_be        <= '0;
            bus.ram_wdata     <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_data     <= '0;
            bus.err_cnt       <= '0;
`ifdef TTS_HOST_TMO_EN
            tmo_cnt           <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        msg <= MSG_W'({msg, bus.in_data});
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            if (bus.in_last) begin
                                state        <= DECODE;
                                bus.in_ready <= 1'b0;
                            end else begin
                                // Overlong message: discard the rest of it.
                                state       <= DRAIN;
                                bus.err_cnt <= sat_inc(bus.err_cnt);
                            end
                        end else if (bus.in_last) begin
                            // Short message: drop and start afresh.
                            beat_cnt    <= '0;
                            bus.err_cnt <= sat_inc(bus.err_cnt);
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready && bus.in_last) begin
                        state <= COLLECT;
                    end
                end

                DECODE: begin
                    if (decode_ok) begin
                        state             <= ISSUE;
                        sel               <= ram_f[NUM_RAMS-1:0];
                        is_write          <= (cmd_f == CMD_WR);
                        bus.ram_req_valid <= ram_f[NUM_RAMS-1:0];
                        bus.ram_we        <= (cmd_f == CMD_WR);
                        bus.ram_addr      <= addr_f;
                        bus.ram_be        <= be_f;
                        bus.ram_wdata     <= data_f;
`ifdef TTS_HOST_TMO_EN
                        tmo_cnt           <= '0;
`endif
                    end else begin
                        state        <= COLLECT;
                        bus.in_ready <= 1'b1;
                        bus.err_cnt  <= sat_inc(bus.err_cnt);
                    end
                end

                ISSUE: begin
                    if (req_hit) begin
                        bus.ram_req_valid <= '0;
`ifdef TTS_HOST_TMO_EN
                        tmo_cnt           <= '0;
`endif
                        if (is_write) begin
                            state        <= COLLECT;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
`ifdef TTS_HOST_TMO_EN
                    else if (tmo_cnt == 16'(TMO_CYC - 1)) begin
                        bus.ram_req_valid <= '0;
                        bus.err_cnt       <= sat_inc(bus.err_cnt);
                        state             <= COLLECT;
                        bus.in_ready      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end

                WAIT_RD: begin
                    if (rd_hit) begin
                        bus.resp_data  <= rd_slice;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end
`ifdef TTS_HOST_TMO_EN
                    else if (tmo_cnt == 16'(TMO_CYC - 1)) begin
                        bus.err_cnt  <= sat_inc(bus.err_cnt);
                        state        <= COLLECT;
                        bus.in_ready <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end

                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= COLLECT;
                        bus.in_ready   <= 1'b1;
                    end
                end

                default: begin
                    state        <= COLLECT;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tts_host_msg_dispatch.sv
// Bench for tts_host_msg_dispatch: directed cases plus randomized messages
// checked against a field-level reference model and a read-data queue.
module tb_tts_host_msg_dispatch;
    localparam int DATA_BYTES = 24;
    localparam int BEAT_BYTES = 8;
    localparam int NUM_RAMS   = 4;
    localparam int BE_BYTES   = DATA_BYTES / 8;
    localparam int MSG_BYTES  = 5 + BE_BYTES + DATA_BYTES;
    localparam int NB         = MSG_BYTES / BEAT_BYTES;
    localparam int DATA_W     = DATA_BYTES * 8;
    localparam int BEAT_W     = BEAT_BYTES * 8;

    logic       clk;
    logic       rst_n;
    logic [2:0] fsm_state;

    tts_host_msg_dispatch_if #(
        .DATA_BYTES(DATA_BYTES), .BEAT_BYTES(BEAT_BYTES), .NUM_RAMS(NUM_RAMS)
    ) bus ();

    tts_host_msg_dispatch #(
        .DATA_BYTES(DATA_BYTES), .BEAT_BYTES(BEAT_BYTES),
        .NUM_RAMS(NUM_RAMS), .TMO_CYC(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int                n_checks = 0;
    int                n_errors = 0;
    int                exp_err  = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [7:0]        msg_bytes [MSG_BYTES];
    logic [BEAT_W-1:0] beat_buf  [NB];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W / 32; i++) d = {d[DATA_W-33:0], 32'($urandom)};
        return d;
    endfunction

    function automatic void model_err_inc();
        if (exp_err < 65535) exp_err++;
    endfunction

    // Lay out the message byte by byte, then cut it into beats, byte 0 first
    // in the MSBs of beat 0.
    function automatic void build_msg(input logic [7:0] cmd, input logic [7:0] ram,
                                      input logic [15:0] addr, input logic [DATA_BYTES-1:0] be,
                                      input logic [DATA_W-1:0] data);
        logic [BEAT_W-1:0] b;
        msg_bytes[0] = cmd;
        msg_bytes[1] = ram;
        msg_bytes[2] = addr[15:8];
        msg_bytes[3] = addr[7:0];
        msg_bytes[4] = 8'($urandom);
        for (int i = 0; i < BE_BYTES; i++)   msg_bytes[5+i] = be[DATA_BYTES-1-8*i -: 8];
        for (int i = 0; i < DATA_BYTES; i++) msg_bytes[5+BE_BYTES+i] = data[DATA_W-1-8*i -: 8];
        for (int k = 0; k < NB; k++) begin
            b = '0;
            for (int j = 0; j < BEAT_BYTES; j++) b = {b[BEAT_W-9:0], msg_bytes[k*BEAT_BYTES+j]};
            beat_buf[k] = b;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_last       = 1'b0;
        bus.ram_req_ready = '0;
        bus.ram_rd_valid  = '0;
        bus.ram_rd_data   = '0;
        bus.resp_ready    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_req_valid", bus.ram_req_valid, 0);
        check("rst_we_addr", {bus.ram_we, bus.ram_addr}, 0);
        check("rst_be_wdata", {bus.ram_be, bus.ram_wdata}, 0);
        check("rst_resp", {bus.resp_valid, bus.resp_data}, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        rst_n = 1'b1;
        exp_err = 0;
        exp_q.delete();
        @(negedge clk);
        check("rst_in_ready_after", bus.in_ready, 1);
    endtask

    // Present one beat, wait (bounded) for acceptance; returns at the negedge
    // after the accepting edge.
    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
        int guard;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int last_idx);
        for (int k = 0; k < nbeats; k++)
            send_beat((k < NB) ? beat_buf[k] : BEAT_W'({$urandom, $urandom}), k == last_idx);
    endtask

    // One whole message: drive it, then check the request / response / drop
    // outcome predicted from the message rules.
    task automatic run_msg(input logic [7:0] cmd, input logic [7:0] ram, input logic [15:0] addr,
                           input logic [DATA_BYTES-1:0] be, input logic [DATA_W-1:0] data,
                           input int nbeats, input int last_idx, input int ready_dly,
                           input int resp_hold);
        logic                framed;
        logic                valid_msg;
        logic [NUM_RAMS-1:0] oh;
        logic [DATA_W-1:0]   rd;
        logic [NUM_RAMS*DATA_W-1:0] rd_bus;
        int                  idx;

        build_msg(cmd, ram, addr, be, data);
        framed    = (nbeats == NB) && (last_idx == NB - 1);
        valid_msg = framed && (cmd == 8'h01 || cmd == 8'h02) &&
                    ($countones(ram) == 1) && (int'(ram) < (1 << NUM_RAMS));
        oh  = ram[NUM_RAMS-1:0];
        idx = 0;
        for (int i = 0; i < NUM_RAMS; i++) if (oh[i]) idx = i;
        if (!valid_msg) model_err_inc();

        send_frame(nbeats, last_idx);

        if (!valid_msg) begin
            repeat (2) begin
                check("drop_no_req", bus.ram_req_valid, 0);
                @(negedge clk);
            end
            check("drop_err_cnt", bus.err_cnt, exp_err);
            return;
        end

        // Decode cycle: no request yet; request appears one cycle later.
        check("lat_decode", bus.ram_req_valid, 0);
        @(negedge clk);
        check("req_valid", bus.ram_req_valid, oh);
        check("req_we", bus.ram_we, cmd == 8'h01);
        check("req_addr", bus.ram_addr, addr);
        check("req_be", bus.ram_be, be);
        check("req_wdata", bus.ram_wdata, data);
        for (int i = 0; i < ready_dly; i++) begin
            bus.ram_req_ready = ~oh & NUM_RAMS'($urandom);
            @(negedge clk);
            check("req_hold", {bus.ram_req_valid, bus.ram_we, bus.ram_addr, bus.ram_be},
                  {oh, cmd == 8'h01, addr, be});
        end
        bus.ram_req_ready = oh | NUM_RAMS'($urandom);
        @(negedge clk);
        bus.ram_req_ready = '0;
        check("req_clear", bus.ram_req_valid, 0);

        if (cmd == 8'h01) begin
            check("wr_no_resp", bus.resp_valid, 0);
            check("wr_back_ready", bus.in_ready, 1);
        end else begin
            repeat ($urandom_range(0, 3)) begin
                bus.ram_rd_valid = ~oh & NUM_RAMS'($urandom);
                for (int i = 0; i < NUM_RAMS; i++) rd_bus[i*DATA_W +: DATA_W] = rand_data();
                bus.ram_rd_data = rd_bus;
                @(negedge clk);
                check("rd_ignore", bus.resp_valid, 0);
            end
            rd = rand_data();
            exp_q.push_back(rd);
            for (int i = 0; i < NUM_RAMS; i++) rd_bus[i*DATA_W +: DATA_W] = rand_data();
            rd_bus[idx*DATA_W +: DATA_W] = rd;
            bus.ram_rd_data  = rd_bus;
            bus.ram_rd_valid = oh;
            @(negedge clk);
            bus.ram_rd_valid = '0;
            bus.ram_rd_data  = '0;
            rd = exp_q.pop_front();
            check("resp_valid", bus.resp_valid, 1);
            check("resp_data", bus.resp_data, rd);
            for (int i = 0; i < resp_hold; i++) begin
                @(negedge clk);
                check("resp_hold", {bus.resp_valid, bus.resp_data}, {1'b1, rd});
            end
            bus.resp_ready = 1'b1;
            @(negedge clk);
            bus.resp_ready = 1'b0;
            check("resp_clear", bus.resp_valid, 0);
        end
        check("ok_err_cnt", bus.err_cnt, exp_err);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  rc;
        logic [7:0]  rr;
        int          mode;
        int          nb;
        int          li;

        do_reset();

        // Write to VRCB, then read from ORCB with a slow request and slow consumer.
        run_msg(8'h01, 8'h04, 16'h0012, 24'hFFFFFF, rand_data(), NB, NB - 1, 0, 0);
        run_msg(8'h02, 8'h08, 16'hBEEF, 24'h0F00F0, rand_data(), NB, NB - 1, 3, 5);

        // Bad selects and unknown command.
        do_reset();
        run_msg(8'h01, 8'h06, 16'h0001, 24'h000001, rand_data(), NB, NB - 1, 0, 0);
        run_msg(8'h02, 8'h10, 16'h0002, 24'h000002, rand_data(), NB, NB - 1, 0, 0);
        run_msg(8'h7F, 8'h01, 16'h0003, 24'h000003, rand_data(), NB, NB - 1, 0, 0);
        check("invalid_err_cnt", bus.err_cnt, 3);

        // Framing errors: early last, then a good message, then missing last.
        do_reset();
        run_msg(8'h01, 8'h01, 16'h1111, 24'hABCDEF, rand_data(), 3, 2, 0, 0);
        check("early_last_err", bus.err_cnt, 1);
        run_msg(8'h02, 8'h02, 16'h2222, 24'h123456, rand_data(), NB, NB - 1, 1, 1);
        run_msg(8'h01, 8'h01, 16'h3333, 24'h654321, rand_data(), NB + 2, NB + 1, 0, 0);
        check("missing_last_err", bus.err_cnt, 2);
        run_msg(8'h01, 8'h02, 16'h4444, 24'hFFFFFF, rand_data(), NB, NB - 1, 0, 0);

        // Asynchronous reset while a request is outstanding.
        build_msg(8'h01, 8'h04, 16'h5555, 24'hFFFFFF, rand_data());
        send_frame(NB, NB - 1);
        @(negedge clk);
        check("pre_rst_req", bus.ram_req_valid, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", bus.ram_req_valid, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        check("async_rst_fields", {bus.ram_we, bus.ram_addr, bus.ram_be, bus.ram_wdata}, 0);
        check("async_rst_resp_err", {bus.resp_valid, bus.resp_data, bus.err_cnt}, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_err = 0;
        repeat (3) begin
            @(negedge clk);
            check("no_replay", bus.ram_req_valid, 0);
        end
        run_msg(8'h02, 8'h01, 16'h6666, 24'h00FF00, rand_data(), NB, NB - 1, 2, 2);

        // Request held off for a long time: must stay asserted.
        run_msg(8'h01, 8'h08, 16'h7777, 24'hF0F0F0, rand_data(), NB, NB - 1, 120, 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            rc = ($urandom_range(0, 9) < 4) ? 8'h01 :
                 ($urandom_range(0, 9) < 8) ? 8'h02 : 8'($urandom);
            rr = ($urandom_range(0, 9) < 8) ? 8'(1 << $urandom_range(0, NUM_RAMS - 1)) : 8'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                li = $urandom_range(0, NB - 2);
                nb = li + 1;
            end else if (mode == 1) begin
                nb = NB + $urandom_range(1, 3);
                li = nb - 1;
            end else begin
                nb = NB;
                li = NB - 1;
            end
            run_msg(rc, rr, 16'($urandom), DATA_BYTES'($urandom), rand_data(), nb, li,
                    $urandom_range(0, 4), $urandom_range(0, 4));
        end

        check("final_exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end
endmodule
